// File: rtl/imeas_stream_arbiter_if.sv
// imeas_stream_arbiter_if: 16-bit Avalon-ST source bundle (out_data/out_valid/out_channel/sop/eop driven by master, out_ready driven by slave)
interface imeas_stream_arbiter_if #(parameter int CHANNEL_WIDTH = 8);
  logic [15:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic out_startofpacket;
  logic out_endofpacket;
  modport master (output out_data, out_valid, out_channel, out_startofpacket, out_endofpacket, input out_ready);
  modport slave (input out_data, out_valid, out_channel, out_startofpacket, out_endofpacket, output out_ready);
endinterface

// File: rtl/imeas_stream_arbiter.sv
// imeas_stream_arbiter: round-robin packetiser of NUM_CH 32-bit samples (in_data/in_valid, enable) onto a 16-bit Avalon-ST source (src), per-channel saturating overflow counters (ovf_count, ovf_clear); define IMEAS_TIMESTAMP_EN for a third timestamp beat
module imeas_stream_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CHANNEL_WIDTH = 8,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic [NUM_CH*32-1:0] in_data,
  input  logic [NUM_CH-1:0] in_valid,
  imeas_stream_arbiter_if.master src,
  input  logic ovf_clear,
  output logic [NUM_CH*OVF_CNT_WIDTH-1:0] ovf_count
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, HI, LO, TS} state_t;
  state_t state_q, state_d;
  logic [NUM_CH-1:0] pend_q, pend_d, cap;
  logic [IW-1:0] ptr_q, ptr_d, gnt, chan_q;
  logic [31:0] hold_q [NUM_CH];
  logic [31:0] word_q;
  logic [OVF_CNT_WIDTH-1:0] ovf_q [NUM_CH];
  logic last_beat, grant;
`ifdef IMEAS_TIMESTAMP_EN
  logic [15:0] ts_cnt_q, ts_word_q;
  logic [15:0] ts_q [NUM_CH];
  assign last_beat = state_q == TS && src.out_ready;
`else
  assign last_beat = state_q == LO && src.out_ready;
`endif
  assign cap = enable ? in_valid : '0;
  assign grant = enable && |pend_q && (state_q == IDLE || last_beat);
  always_comb begin
    gnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pend_q[IW'((int'(ptr_q) + i) % NUM_CH)]) gnt = IW'((int'(ptr_q) + i) % NUM_CH);
    ptr_d = grant ? IW'((int'(gnt) + 1) % NUM_CH) : ptr_q;
    for (int k = 0; k < NUM_CH; k++)
      pend_d[k] = cap[k] | (pend_q[k] & ~(grant && gnt == IW'(k)));
  end
  always_comb begin
    state_d = state_q;
    if (grant) state_d = HI;
    else if (last_beat || state_q == IDLE) state_d = IDLE;
    else if (src.out_ready) state_d = state_q == HI ? LO : TS;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q <= '0;
      ptr_q <= '0;
      chan_q <= '0;
      word_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        hold_q[k] <= '0;
        ovf_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      ptr_q <= ptr_d;
      chan_q <= grant ? gnt : chan_q;
      word_q <= grant ? hold_q[gnt] : word_q;
      for (int k = 0; k < NUM_CH; k++) begin
        hold_q[k] <= cap[k] ? in_data[32*k +: 32] : hold_q[k];
        ovf_q[k] <= ovf_clear ? '0 :
                    (cap[k] && pend_q[k] && !(grant && gnt == IW'(k)) && !(&ovf_q[k])) ? ovf_q[k] + 1'b1 : ovf_q[k];
      end
    end
  end
`ifdef IMEAS_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_word_q <= '0;
      for (int k = 0; k < NUM_CH; k++) ts_q[k] <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      ts_word_q <= grant ? ts_q[gnt] : ts_word_q;
      for (int k = 0; k < NUM_CH; k++) ts_q[k] <= cap[k] ? ts_cnt_q : ts_q[k];
    end
  end
  assign src.out_data = state_q == HI ? word_q[31:16] : state_q == LO ? word_q[15:0] : state_q == TS ? ts_word_q : '0;
  assign src.out_endofpacket = state_q == TS;
`else
  assign src.out_data = state_q == HI ? word_q[31:16] : state_q == LO ? word_q[15:0] : '0;
  assign src.out_endofpacket = state_q == LO;
`endif
  assign src.out_valid = state_q != IDLE;
  assign src.out_startofpacket = state_q == HI;
  assign src.out_channel = CHANNEL_WIDTH'(chan_q);
  for (genvar g = 0; g < NUM_CH; g++) assign ovf_count[g*OVF_CNT_WIDTH +: OVF_CNT_WIDTH] = ovf_q[g];
endmodule

// File: tb/tb_imeas_stream_arbiter.sv
// tb_imeas_stream_arbiter: directed table and sequence checks of imeas_stream_arbiter framing, arbitration, backpressure, overflow, reset and enable
module tb_imeas_stream_arbiter;
  logic clk = 0;
  logic reset = 1;
  logic enable = 1;
  logic [127:0] in_data = '0;
  logic [3:0] in_valid = '0;
  logic ovf_clear = 0;
  logic [31:0] ovf_count;
  int total = 0;
  int passed = 0;
  imeas_stream_arbiter_if #(.CHANNEL_WIDTH(8)) st();
  imeas_stream_arbiter #(.NUM_CH(4), .CHANNEL_WIDTH(8), .OVF_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .src(st), .ovf_clear(ovf_clear), .ovf_count(ovf_count)
  );
  always #5 clk = ~clk;
  typedef struct {int ch; logic [31:0] data; logic [15:0] hi; logic [15:0] lo;} vec_t;
  vec_t vec [4];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic beat(input string nm, input logic [15:0] d, input int ch, input logic sop, input logic eop);
    chk(nm, {st.out_valid, st.out_startofpacket, st.out_endofpacket, st.out_channel, st.out_data},
        {1'b1, sop, eop, 8'(ch), d});
  endtask
  task automatic strobe(input int ch, input logic [31:0] d);
    in_valid = '0;
    in_valid[ch] = 1'b1;
    in_data[32*ch +: 32] = d;
    tick();
    in_valid = '0;
  endtask
  initial begin
    vec[0] = '{2, 32'hDEADBEEF, 16'hDEAD, 16'hBEEF};
    vec[1] = '{0, 32'h12345678, 16'h1234, 16'h5678};
    vec[2] = '{3, 32'hCAFEF00D, 16'hCAFE, 16'hF00D};
    vec[3] = '{1, 32'h0000FFFF, 16'h0000, 16'hFFFF};
    st.out_ready = 1;
    tick();
    tick();
    chk("reset_outputs", {st.out_valid, st.out_startofpacket, st.out_endofpacket, st.out_channel, st.out_data}, 0);
    chk("reset_ovf", ovf_count, 0);
    reset = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      strobe(vec[i].ch, vec[i].data);
      chk("single_no_beat_yet", st.out_valid, 0);
      tick();
      beat("single_hi", vec[i].hi, vec[i].ch, 1, 0);
      tick();
      beat("single_lo", vec[i].lo, vec[i].ch, 0, 1);
      tick();
      chk("single_idle_after", st.out_valid, 0);
    end
    chk("single_ovf_zero", ovf_count, 0);
    reset = 1;
    tick();
    reset = 0;
    for (int k = 0; k < 4; k++) in_data[32*k +: 32] = {16'hA000 + 16'(k), 16'hB000 + 16'(k)};
    in_valid = '1;
    tick();
    in_valid = '0;
    chk("burst_no_beat_yet", st.out_valid, 0);
    tick();
    for (int b = 0; b < 8; b++) begin
      beat("burst_beat", b % 2 == 0 ? 16'hA000 + 16'(b / 2) : 16'hB000 + 16'(b / 2), b / 2, b % 2 == 0, b % 2 == 1);
      tick();
    end
    chk("burst_idle_after", st.out_valid, 0);
    st.out_ready = 0;
    strobe(3, 32'h13572468);
    tick();
    for (int c = 0; c < 5; c++) begin
      beat("stall_hi_held", 16'h1357, 3, 1, 0);
      tick();
    end
    beat("stall_hi_held", 16'h1357, 3, 1, 0);
    st.out_ready = 1;
    tick();
    beat("stall_lo", 16'h2468, 3, 0, 1);
    tick();
    chk("stall_idle_after", st.out_valid, 0);
    st.out_ready = 0;
    strobe(0, 32'h0BADC0DE);
    tick();
    beat("ovf_block_hi", 16'h0BAD, 0, 1, 0);
    strobe(1, 32'h1);
    strobe(1, 32'h2);
    strobe(1, 32'h3);
    chk("ovf_count_2", ovf_count, 32'h0000_0200);
    st.out_ready = 1;
    tick();
    beat("ovf_block_lo", 16'hC0DE, 0, 0, 1);
    tick();
    beat("ovf_newest_hi", 16'h0000, 1, 1, 0);
    tick();
    beat("ovf_newest_lo", 16'h0003, 1, 0, 1);
    tick();
    chk("ovf_idle_after", st.out_valid, 0);
    st.out_ready = 0;
    strobe(2, 32'h22223333);
    tick();
    in_data[63:32] = 32'h11115555;
    in_valid[1] = 1'b1;
    for (int c = 0; c < 301; c++) tick();
    chk("ovf_saturated", ovf_count, 32'h0000_FF00);
    ovf_clear = 1;
    tick();
    chk("ovf_clear_wins", ovf_count, 0);
    ovf_clear = 0;
    in_valid = '0;
    tick();
    chk("ovf_stays_clear", ovf_count, 0);
    st.out_ready = 1;
    tick();
    beat("sat_drain_lo", 16'h3333, 2, 0, 1);
    tick();
    beat("sat_drain_hi", 16'h1111, 1, 1, 0);
    tick();
    beat("sat_drain_lo", 16'h5555, 1, 0, 1);
    tick();
    chk("sat_idle_after", st.out_valid, 0);
    strobe(0, 32'hA);
    in_valid[0] = 1'b1;
    in_data[31:0] = 32'hB;
    tick();
    in_valid = '0;
    beat("same_edge_a_hi", 16'h0000, 0, 1, 0);
    tick();
    beat("same_edge_a_lo", 16'h000A, 0, 0, 1);
    tick();
    beat("same_edge_b_hi", 16'h0000, 0, 1, 0);
    tick();
    beat("same_edge_b_lo", 16'h000B, 0, 0, 1);
    tick();
    chk("same_edge_idle", st.out_valid, 0);
    chk("same_edge_no_ovf", ovf_count, 0);
    strobe(3, 32'h77778888);
    tick();
    in_valid[2] = 1'b1;
    in_data[95:64] = 32'h99990000;
    tick();
    in_valid = '0;
    beat("rst_mid_lo", 16'h8888, 3, 0, 1);
    reset = 1;
    tick();
    chk("rst_abort", {st.out_valid, st.out_startofpacket, st.out_endofpacket, st.out_data}, 0);
    reset = 0;
    tick();
    tick();
    tick();
    chk("rst_pend_cleared", st.out_valid, 0);
    enable = 0;
    in_valid = '1;
    tick();
    tick();
    chk("disabled_no_beat", st.out_valid, 0);
    in_valid = '0;
    enable = 1;
    tick();
    tick();
    tick();
    chk("disabled_not_captured", st.out_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
